up_down_counter_4b: RTL and testbench

- Synchronous binary up/down counter, default width 4 bits.
- Direction is selected every clock by a single input.
- Modular wrap-around in both directions, plus status flags (zero, max, wrap pulse, saturating wrap tally) for downstream monitoring.
- Leaf block intended for timers, address sequencing and lab exercises.

---
 rtl/up_down_counter_4b.sv | 60 ++++++
 tb/tb_up_down_counter_4b.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_4b.sv
// Synchronous up/down counter with modular wrap, zero/max decode,
// a registered wrap pulse and a saturating wrap tally.
module up_down_counter_4b #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned WRAPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ud,
    output logic [WIDTH-1:0] counter,
    output logic             is_zero,
    output logic             is_max,
    output logic             wrap,
    output logic [WRAPW-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WRAPW-1:0] WC_MAX   = {WRAPW{1'b1}};

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             wrap_q, wrap_d;
    logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;

    // Next-state: step in the sampled direction; flag a wrap at either end.
    always_comb begin
        counter_d  = counter_q;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (ud) begin
            counter_d = counter_q + WIDTH'(1);
            wrap_d    = (counter_q == CNT_MAX);
        end else begin
            counter_d = counter_q - WIDTH'(1);
            wrap_d    = (counter_q == CNT_ZERO);
        end
        if (wrap_d && (wrap_cnt_q != WC_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + WRAPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q  <= CNT_ZERO;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= {WRAPW{1'b0}};
        end else begin
            counter_q  <= counter_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign counter  = counter_q;
    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;
    assign is_zero  = (counter_q == CNT_ZERO);
    assign is_max   = (counter_q == CNT_MAX);

endmodule

// File: tb/tb_up_down_counter_4b.sv
// Scoreboard bench for up_down_counter_4b: default instance plus a WRAPW=2
// instance sharing the same stimulus to exercise tally saturation.
module tb_up_down_counter_4b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ud  = 1'b1;

    logic [3:0] cnt_a, cnt_b;
    logic       zero_a, max_a, wrap_a;
    logic       zero_b, max_b, wrap_b;
    logic [7:0] wc_a;
    logic [1:0] wc_b;

    up_down_counter_4b #(.WIDTH(4), .WRAPW(8)) dut_a (
        .clk(clk), .rst(rst), .ud(ud),
        .counter(cnt_a), .is_zero(zero_a), .is_max(max_a),
        .wrap(wrap_a), .wrap_cnt(wc_a)
    );

    up_down_counter_4b #(.WIDTH(4), .WRAPW(2)) dut_b (
        .clk(clk), .rst(rst), .ud(ud),
        .counter(cnt_b), .is_zero(zero_b), .is_max(max_b),
        .wrap(wrap_b), .wrap_cnt(wc_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cnt;
        int    zero;
        int    max;
        int    wrap;
        int    wca;
        int    wcb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state, stepped once per edge by the stimulus process
    int m_cnt  = 0;
    int m_wrap = 0;
    int m_n    = 0;

    task automatic chk(input string name, input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, exp);
    endtask

    task automatic step(input logic r, input logic u, input string tag);
        exp_t e;
        rst = r;
        ud  = u;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_wrap = 0; m_n = 0;
        end else if (u) begin
            m_wrap = (m_cnt == 15) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % 16;
        end else begin
            m_wrap = (m_cnt == 0) ? 1 : 0;
            m_cnt  = (m_cnt + 15) % 16;
        end
        if (!r && m_wrap == 1) m_n++;
        e.tag  = tag;
        e.cnt  = m_cnt;
        e.zero = (m_cnt == 0)  ? 1 : 0;
        e.max  = (m_cnt == 15) ? 1 : 0;
        e.wrap = m_wrap;
        e.wca  = (m_n > 255) ? 255 : m_n;
        e.wcb  = (m_n > 3) ? 3 : m_n;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every clock presents a new output; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("counter",  e.tag, int'(cnt_a),  e.cnt);
                chk("is_zero",  e.tag, int'(zero_a), e.zero);
                chk("is_max",   e.tag, int'(max_a),  e.max);
                chk("wrap",     e.tag, int'(wrap_a), e.wrap);
                chk("wrap_cnt", e.tag, int'(wc_a),   e.wca);
                chk("b_counter",  e.tag, int'(cnt_b),  e.cnt);
                chk("b_wrap",     e.tag, int'(wrap_b), e.wrap);
                chk("b_wrap_cnt", e.tag, int'(wc_b),   e.wcb);
            end
        end
    end

    // Directed hand-checked values at key points, independent of the model
    task automatic hand(input string name, input int act, input int exp);
        chk(name, "hand", act, exp);
    endtask

    initial begin
        @(negedge clk);
        step(1'b1, 1'b1, "reset");
        hand("rst_counter", int'(cnt_a), 0);
        hand("rst_is_zero", int'(zero_a), 1);
        hand("rst_wrap_cnt", int'(wc_a), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "reset_hold");
        hand("hold_counter", int'(cnt_a), 0);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, "up");
        hand("up_end_counter", int'(cnt_a), 0);
        hand("up_end_wrap", int'(wrap_a), 1);
        hand("up_end_wrap_cnt", int'(wc_a), 1);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, "down");
            if (i == 0) begin
                hand("down_first_counter", int'(cnt_a), 15);
                hand("down_first_is_max", int'(max_a), 1);
                hand("down_first_wrap", int'(wrap_a), 1);
            end
        end
        hand("down_end_wrap_cnt", int'(wc_a), 2);

        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "to7");
        hand("at7", int'(cnt_a), 7);
        step(1'b0, 1'b1, "rev"); hand("rev_8", int'(cnt_a), 8);
        step(1'b0, 1'b1, "rev"); hand("rev_9", int'(cnt_a), 9);
        step(1'b0, 1'b0, "rev"); hand("rev_8b", int'(cnt_a), 8);
        step(1'b0, 1'b0, "rev"); hand("rev_7", int'(cnt_a), 7);
        step(1'b0, 1'b1, "rev"); hand("rev_8c", int'(cnt_a), 8);
        hand("rev_wrap", int'(wrap_a), 0);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "to12");
        hand("at12", int'(cnt_a), 12);
        step(1'b1, 1'b1, "mid_reset");
        hand("mid_rst_counter", int'(cnt_a), 0);
        hand("mid_rst_wrap_cnt", int'(wc_a), 0);
        step(1'b0, 1'b0, "release_down");
        hand("rel_counter", int'(cnt_a), 15);
        hand("rel_wrap", int'(wrap_a), 1);
        hand("rel_wrap_cnt", int'(wc_a), 1);

        step(1'b1, 1'b1, "sat_reset");
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, "sat_up");
        hand("sat_b_wrap_cnt", int'(wc_b), 3);
        hand("sat_b_wrap", int'(wrap_b), 1);
        hand("sat_a_wrap_cnt", int'(wc_a), 5);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
